// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus layouts, control bit positions
// and the FSM state encoding.
package mem_stage_pkg;

    localparam int EXE_MEM_W  = 106;
    localparam int MEM_WB_W   = 70;

    // Bit positions of mem_control inside the EXE->MEM bus
    localparam int CTRL_LOAD  = 105;
    localparam int CTRL_STORE = 104;
    localparam int CTRL_WORD  = 103;
    localparam int CTRL_SIGN  = 102;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Field view of the EXE->MEM bus; order matches the packed bit layout
    typedef struct packed {
        logic        inst_load;
        logic        inst_store;
        logic        ls_word;
        logic        lb_sign;
        logic [31:0] store_data;
        logic [31:0] alu_result;
        logic        rf_wen;
        logic [4:0]  rf_wdest;
        logic [31:0] pc;
    } exe_mem_t;

    function automatic logic [MEM_WB_W-1:0] pack_wb(input logic        rf_wen,
                                                    input logic [4:0]  rf_wdest,
                                                    input logic [31:0] result,
                                                    input logic [31:0] pc);
        return {rf_wen, rf_wdest, result, pc};
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the memory stage: store lane enables / replication
// and load lane extraction with sign or zero extension.
module mem_align (
    input  logic        store_i,
    input  logic        word_i,
    input  logic        sign_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0] lane [4];
    logic [7:0] sel_byte;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata_i[8*gi +: 8];
    end

    assign sel_byte = lane[addr_lo_i];

    always_comb begin
        wen_o       = 4'b0000;
        wdata_o     = word_i ? store_data_i : {4{store_data_i[7:0]}};
        load_data_o = rdata_i;
        if (store_i) begin
            wen_o = word_i ? 4'b1111 : (4'b0001 << addr_lo_i);
        end
        if (!word_i) begin
            load_data_o = {{24{sign_i & sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: non-memory instructions pass straight through in IDLE;
// loads/stores are latched and walked through IDLE -> REQ -> DONE.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    output logic                 dm_req,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [31:0]          MEM_pc
);

    state_e               state_q, state_d;
    logic [EXE_MEM_W-1:0] bus_q, bus_d;
    logic [31:0]          result_q, result_d;

    exe_mem_t    live;
    exe_mem_t    lat;
    logic        live_is_mem;
    logic [3:0]  align_wen;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    assign live        = EXE_MEM_bus_r;
    assign lat         = bus_q;
    assign live_is_mem = EXE_MEM_bus_r[CTRL_LOAD] | EXE_MEM_bus_r[CTRL_STORE];

    mem_align u_align (
        .store_i      (bus_q[CTRL_STORE]),
        .word_i       (bus_q[CTRL_WORD]),
        .sign_i       (bus_q[CTRL_SIGN]),
        .addr_lo_i    (lat.alu_result[1:0]),
        .store_data_i (lat.store_data),
        .rdata_i      (dm_rdata),
        .wen_o        (align_wen),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

    // Address and data always come from the latched copy so they hold steady in REQ
    assign dm_addr  = {lat.alu_result[31:2], 2'b00};
    assign dm_wdata = align_wdata;

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        result_d = result_q;
        MEM_over = 1'b0;
        dm_req   = 1'b0;
        dm_wen   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (MEM_valid) begin
                    if (live_is_mem) begin
                        bus_d   = EXE_MEM_bus_r;
                        state_d = ST_REQ;
                    end else begin
                        MEM_over = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                dm_req = 1'b1;
                dm_wen = align_wen;
                if (dm_ack) begin
                    result_d = bus_q[CTRL_LOAD] ? align_load : lat.alu_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                MEM_over = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshakes stay quiet for the whole reset cycle, not just after it
        if (reset) begin
            MEM_over = 1'b0;
            dm_req   = 1'b0;
            dm_wen   = 4'b0000;
        end
    end

    always_comb begin
        if (state_q == ST_IDLE) begin
            MEM_WB_bus = pack_wb(live.rf_wen, live.rf_wdest, live.alu_result, live.pc);
            MEM_pc     = live.pc;
        end else begin
            MEM_WB_bus = pack_wb(lat.rf_wen, lat.rf_wdest, result_q, lat.pc);
            MEM_pc     = lat.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bus_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            result_q <= result_d;
        end
    end

endmodule
